// File: rtl/prp_request_arbiter.sv
// -----------------------------------------------------------------------------
// prp_request_arbiter
//
// Shares one iterative Swap-or-Not PRP engine between NUM_REQ query lanes.
// Lanes are served round-robin, and only one operation is in flight at a time.
// The accepted operand and configuration are held in registers that drive the
// engine. The block issues the engine start pulse and waits for done under a
// watchdog. It then presents the lane-tagged result on a valid/ready channel.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   req_valid/ready   per-lane request handshake (ready is one-hot or zero)
//   req_x             per-lane operand, lane i at [i*WIDTH +: WIDTH]
//   req_direction     per-lane direction (0 forward, 1 inverse)
//   cfg_domain        PRP domain N, sampled on accept
//   cfg_num_rounds    round count, sampled on accept
//   prp_start         one-cycle engine start pulse
//   prp_x_in, prp_direction, prp_domain, prp_num_rounds
//                     registered engine operand/config, held until next accept
//   prp_busy, prp_done, prp_x_out
//                     engine status, completion pulse and result
//   rsp_valid/ready   response handshake
//   rsp_lane, rsp_x, rsp_err
//                     originating lane, result, error (bad config or timeout)
// -----------------------------------------------------------------------------
module prp_request_arbiter #(
    parameter int WIDTH   = 64,
    parameter int NUM_REQ = 4,
    parameter int LANE_W  = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_x,
    input  logic [NUM_REQ-1:0]       req_direction,
    input  logic [WIDTH-1:0]         cfg_domain,
    input  logic [7:0]               cfg_num_rounds,
    output logic                     prp_start,
    output logic [WIDTH-1:0]         prp_x_in,
    output logic                     prp_direction,
    output logic [WIDTH-1:0]         prp_domain,
    output logic [7:0]               prp_num_rounds,
    input  logic                     prp_busy,
    input  logic                     prp_done,
    input  logic [WIDTH-1:0]         prp_x_out,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [LANE_W-1:0]        rsp_lane,
    output logic [WIDTH-1:0]         rsp_x,
    output logic                     rsp_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    // Watchdog is sized to hold TIMEOUT-1; at least one bit for tiny TIMEOUTs.
    localparam int              WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    // One extra bit lets last_grant + offset exceed NUM_REQ before the wrap.
    localparam int               CAND_W = LANE_W + 1;
    localparam logic [CAND_W-1:0] NREQ  = CAND_W'(NUM_REQ);

    logic [1:0]                     state;
    logic [LANE_W-1:0]              last_grant;
    logic [WD_W-1:0]                wdog;

    logic [NUM_REQ-1:0][WIDTH-1:0]  lane_x;
    logic [LANE_W-1:0]              grant;
    logic                           grant_any;
    logic [CAND_W-1:0]              cand;
    logic                           accept;
    logic                           cfg_bad;

    assign lane_x = req_x;

    // Round-robin search: the first valid lane at or after last_grant+1,
    // wrapping at NUM_REQ. last_grant is searched last, so a lone requester
    // can still be re-granted.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant} + CAND_W'(k);
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!grant_any && req_valid[cand[LANE_W-1:0]]) begin
                grant     = cand[LANE_W-1:0];
                grant_any = 1'b1;
            end
        end
    end

    assign accept    = (state == IDLE) && grant_any;
    assign req_ready = accept ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant) : '0;
    assign rsp_valid = (state == RESP);

    // A zero round count or a domain below 2 cannot be permuted. Such a
    // request is answered with an error and never reaches the engine.
    assign cfg_bad   = (cfg_num_rounds == 8'd0) || (cfg_domain < WIDTH'(2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            last_grant     <= LANE_W'(NUM_REQ - 1);
            wdog           <= '0;
            prp_start      <= 1'b0;
            prp_x_in       <= '0;
            prp_direction  <= 1'b0;
            prp_domain     <= '0;
            prp_num_rounds <= '0;
            rsp_lane       <= '0;
            rsp_x          <= '0;
            rsp_err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        prp_x_in       <= lane_x[grant];
                        prp_direction  <= req_direction[grant];
                        prp_domain     <= cfg_domain;
                        prp_num_rounds <= cfg_num_rounds;
                        rsp_lane       <= grant;
                        last_grant     <= grant;
                        if (cfg_bad) begin
                            rsp_err <= 1'b1;
                            rsp_x   <= '0;
                            state   <= RESP;
                        end else begin
                            state   <= START;
                        end
                    end
                end

                START: begin
                    // Hold off until the engine has finished any previous work.
                    if (!prp_busy) begin
                        prp_start <= 1'b1;
                        wdog      <= '0;
                        state     <= WAIT;
                    end
                end

                WAIT: begin
                    prp_start <= 1'b0;
                    if (wdog != '1) begin
                        wdog <= wdog + 1'b1;
                    end
                    // A done in the same cycle as the watchdog expiry takes
                    // priority, so a result that arrives just in time is kept.
                    if (prp_done) begin
                        rsp_x   <= prp_x_out;
                        rsp_err <= 1'b0;
                        state   <= RESP;
                    end else if (wdog == WD_LAST) begin
                        rsp_x   <= '0;
                        rsp_err <= 1'b1;
                        state   <= RESP;
                    end
                end

                RESP: begin
                    // Outside WAIT, prp_done is ignored, including a late
                    // done that follows a timeout.
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prp_request_arbiter.sv
module tb_prp_request_arbiter;

    localparam int WIDTH   = 64;
    localparam int NUM_REQ = 4;
    localparam int LANE_W  = 2;
    localparam int TIMEOUT = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0][WIDTH-1:0] lane_x;
    logic [NUM_REQ*WIDTH-1:0]      req_x;
    logic [NUM_REQ-1:0]            req_direction;
    logic [WIDTH-1:0]              cfg_domain;
    logic [7:0]                    cfg_num_rounds;
    logic                          prp_start;
    logic [WIDTH-1:0]              prp_x_in;
    logic                          prp_direction;
    logic [WIDTH-1:0]              prp_domain;
    logic [7:0]                    prp_num_rounds;
    logic                          prp_busy;
    logic                          prp_done;
    logic [WIDTH-1:0]              prp_x_out;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [LANE_W-1:0]             rsp_lane;
    logic [WIDTH-1:0]              rsp_x;
    logic                          rsp_err;

    assign req_x = lane_x;

    prp_request_arbiter #(
        .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .LANE_W(LANE_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x),
        .req_direction(req_direction),
        .cfg_domain(cfg_domain), .cfg_num_rounds(cfg_num_rounds),
        .prp_start(prp_start), .prp_x_in(prp_x_in), .prp_direction(prp_direction),
        .prp_domain(prp_domain), .prp_num_rounds(prp_num_rounds),
        .prp_busy(prp_busy), .prp_done(prp_done), .prp_x_out(prp_x_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_lane(rsp_lane),
        .rsp_x(rsp_x), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int errors    = 0;
    int rsp_cnt   = 0;
    int start_cnt = 0;

    typedef struct packed {
        logic [LANE_W-1:0] lane;
        logic [WIDTH-1:0]  x;
        logic              err;
    } rsp_t;

    rsp_t sb[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_rsp(input int lane, input logic [WIDTH-1:0] x, input logic err);
        rsp_t e;
        e.lane = LANE_W'(lane);
        e.x    = x;
        e.err  = err;
        sb.push_back(e);
    endtask

    // Engine model: result is operand+1 after eng_lat cycles unless hung.
    int               eng_cnt  = -1;
    int               eng_lat  = 3;
    logic             eng_hang = 1'b0;
    logic             eng_done = 1'b0;
    logic [WIDTH-1:0] eng_x    = '0;
    logic             tb_busy  = 1'b0;
    logic             tb_done  = 1'b0;
    logic [WIDTH-1:0] tb_x     = '0;

    assign prp_busy  = tb_busy | (eng_cnt >= 0);
    assign prp_done  = eng_done | tb_done;
    assign prp_x_out = tb_done ? tb_x : eng_x;

    always begin
        @(posedge clk);
        #1;
        eng_done = 1'b0;
        if (!rst_n) begin
            eng_cnt = -1;
        end else if (prp_start && !eng_hang) begin
            eng_cnt = eng_lat;
            eng_x   = prp_x_in + 64'd1;
        end else if (eng_cnt > 0) begin
            eng_cnt--;
        end
        if (eng_cnt == 0) begin
            eng_done = 1'b1;
            eng_cnt  = -1;
        end
    end

    // Response monitor: inputs only change just after posedge, so values seen
    // at negedge are the ones the next posedge will act on.
    always @(negedge clk) begin : mon
        rsp_t e;
        if (rst_n && prp_start) start_cnt++;
        if (rst_n && rsp_valid && rsp_ready) begin
            rsp_cnt++;
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL rsp_unexpected observed lane=%0d x=%0h err=%0b expected=none",
                       rsp_lane, rsp_x, rsp_err);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rsp_lane", rsp_lane, e.lane);
                chk("rsp_x", rsp_x, e.x);
                chk("rsp_err", rsp_err, e.err);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_rsp(input int target, input string tag);
        int n;
        n = 0;
        while (rsp_cnt < target && n < 500) begin
            tick(1);
            n++;
        end
        chk({tag, "_rsp_arrived"}, rsp_cnt >= target, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {req_ready, prp_start, prp_direction, prp_num_rounds,
                            rsp_valid, rsp_lane, rsp_err}, '0);
        chk({tag, "_x_in"}, prp_x_in, '0);
        chk({tag, "_domain"}, prp_domain, '0);
        chk({tag, "_rsp_x"}, rsp_x, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int s;
        int n;
        req_valid      = '0;
        req_direction  = '0;
        lane_x         = '0;
        cfg_domain     = 64'd1000;
        cfg_num_rounds = 8'd8;
        rsp_ready      = 1'b1;
        rst_n          = 1'b0;
        tick(2);
        chk_zero("reset");
        rst_n = 1'b1;
        tick(1);

        // Round-robin across all four lanes, then lane 0 again.
        lane_x[0] = 64'd10; lane_x[1] = 64'd20; lane_x[2] = 64'd30; lane_x[3] = 64'd40;
        req_valid = 4'hF;
        #1;
        chk("rr_first_grant", req_ready, 4'b0001);
        expect_rsp(0, 64'd11, 1'b0);
        expect_rsp(1, 64'd21, 1'b0);
        expect_rsp(2, 64'd31, 1'b0);
        expect_rsp(3, 64'd41, 1'b0);
        expect_rsp(0, 64'd11, 1'b0);
        wait_rsp(5, "rr");
        req_valid = '0;
        chk("rr_cfg_latched", {prp_domain, prp_num_rounds}, {64'd1000, 8'd8});

        // Single lane 2, inverse, with 20 cycles of backpressure.
        rsp_ready     = 1'b0;
        lane_x[2]     = 64'd5;
        req_direction = 4'b0100;
        req_valid     = 4'b0100;
        expect_rsp(2, 64'd6, 1'b0);
        tick(1);
        req_valid = 4'b0101;
        chk("bp_operand", {prp_x_in, prp_direction}, {64'd5, 1'b1});
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick(1);
            n++;
        end
        chk("bp_rsp_valid", rsp_valid, 1'b1);
        s = start_cnt;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("bp_hold", {rsp_valid, rsp_lane, rsp_x, req_ready},
                {1'b1, 2'd2, 64'd6, 4'b0000});
        end
        chk("bp_no_start", start_cnt, s);
        req_valid     = '0;
        req_direction = '0;
        rsp_ready     = 1'b1;
        wait_rsp(6, "bp");

        // Config reject: rounds=0, then domain=1.
        s = start_cnt;
        cfg_num_rounds = 8'd0;
        lane_x[1]      = 64'd33;
        req_valid      = 4'b0010;
        expect_rsp(1, 64'd0, 1'b1);
        tick(1);
        req_valid = '0;
        chk("rej_rounds_immediate", {rsp_valid, rsp_err}, 2'b11);
        wait_rsp(7, "rej_rounds");
        cfg_num_rounds = 8'd8;
        cfg_domain     = 64'd1;
        req_valid      = 4'b0010;
        expect_rsp(1, 64'd0, 1'b1);
        tick(1);
        req_valid = '0;
        chk("rej_domain_immediate", {rsp_valid, rsp_err}, 2'b11);
        wait_rsp(8, "rej_domain");
        cfg_domain = 64'd1000;
        chk("rej_no_start", start_cnt, s);

        // Timeout: engine never answers.
        eng_hang  = 1'b1;
        lane_x[3] = 64'd7;
        req_valid = 4'b1000;
        expect_rsp(3, 64'd0, 1'b1);
        tick(1);
        req_valid = '0;
        tick(1);
        chk("to_start", prp_start, 1'b1);
        n = 0;
        while (!rsp_valid && n < 100) begin
            tick(1);
            n++;
        end
        chk("to_wait_cycles", n, 16);
        chk("to_err", {rsp_valid, rsp_err, rsp_x}, {1'b1, 1'b1, 64'd0});
        wait_rsp(9, "to");
        tb_x    = 64'd99;
        tb_done = 1'b1;
        tick(1);
        tb_done = 1'b0;
        chk("late_done_ignored", rsp_valid, 1'b0);
        tick(1);
        chk("late_done_still_idle", rsp_valid, 1'b0);
        eng_hang  = 1'b0;
        lane_x[0] = 64'd50;
        req_valid = 4'b0001;
        expect_rsp(0, 64'd51, 1'b0);
        tick(1);
        req_valid = '0;
        wait_rsp(10, "after_to");

        // Busy gating: start waits for busy to drop.
        tb_busy   = 1'b1;
        lane_x[1] = 64'd60;
        req_valid = 4'b0010;
        expect_rsp(1, 64'd61, 1'b0);
        tick(1);
        req_valid = '0;
        s = start_cnt;
        tick(5);
        chk("busy_no_start", {prp_start, start_cnt == s}, {1'b0, 1'b1});
        tb_busy = 1'b0;
        tick(1);
        chk("busy_release_start", prp_start, 1'b1);
        wait_rsp(11, "busy");

        // Done coincident with watchdog expiry: the result wins.
        eng_hang  = 1'b1;
        lane_x[2] = 64'd70;
        req_valid = 4'b0100;
        expect_rsp(2, 64'd123, 1'b0);
        tick(1);
        req_valid = '0;
        tick(1);
        chk("coin_start", prp_start, 1'b1);
        tick(15);
        chk("coin_pre", rsp_valid, 1'b0);
        tb_x    = 64'd123;
        tb_done = 1'b1;
        tick(1);
        tb_done = 1'b0;
        chk("coin_result", {rsp_valid, rsp_err, rsp_x}, {1'b1, 1'b0, 64'd123});
        wait_rsp(12, "coin");

        // Reset in the middle of WAIT.
        lane_x[1] = 64'd80;
        req_valid = 4'b0010;
        tick(1);
        req_valid = '0;
        tick(3);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        tick(1);
        rst_n     = 1'b1;
        eng_hang  = 1'b0;
        lane_x[0] = 64'd90;
        lane_x[3] = 64'd95;
        req_valid = 4'b1001;
        #1;
        chk("rst_priority", req_ready, 4'b0001);
        expect_rsp(0, 64'd91, 1'b0);
        tick(1);
        req_valid = '0;
        tick(1);
        chk("rst_start", prp_start, 1'b1);
        wait_rsp(13, "rst");

        tick(2);
        chk("sb_empty", sb.size(), 0);
        chk("rsp_total", rsp_cnt, 13);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
